// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if: bundles the instruction handshake, the ALU operand/result
// bus, the completion/writeback outputs and the debug read port of
// alu_sequencer.
//   slave  : sequencer side (accepts instructions, drives ALU operands)
//   master : environment side (instruction source, combinational ALU, debug)
// Ports (signals):
//   instr_valid/instr_ready/instr[7:0]/imm : instruction handshake
//   alu_a/alu_b/alu_op -> ALU, alu_result/alu_cf/alu_sf/alu_zf <- ALU
//   done/wb_data/flags : completion pulse, writeback value, committed flags
//   dbg_addr/dbg_data  : combinational register-file peek
interface alu_sequencer_if #(
  parameter int WIDTH = 7,
  parameter int NREGS = 4
);
  localparam int AW = $clog2(NREGS);

  logic             instr_valid;
  logic             instr_ready;
  logic [7:0]       instr;
  logic [WIDTH-1:0] imm;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic             alu_op;
  logic [WIDTH-1:0] alu_result;
  logic             alu_cf;
  logic             alu_sf;
  logic             alu_zf;
  logic             done;
  logic [WIDTH-1:0] wb_data;
  logic [2:0]       flags;
  logic [AW-1:0]    dbg_addr;
  logic [WIDTH-1:0] dbg_data;

  modport slave (
    input  instr_valid, instr, imm, alu_result, alu_cf, alu_sf, alu_zf, dbg_addr,
    output instr_ready, alu_a, alu_b, alu_op, done, wb_data, flags, dbg_data
  );

  modport master (
    output instr_valid, instr, imm, alu_result, alu_cf, alu_sf, alu_zf, dbg_addr,
    input  instr_ready, alu_a, alu_b, alu_op, done, wb_data, flags, dbg_data
  );
endinterface

// File: rtl/alu_sequencer.sv
// alu_sequencer: four-state (IDLE/READ/EXEC/WB) sequencer for the external
// combinational NOR/ROR ALU. One instruction per handshake; operands come
// from a small register file, the result is written back and {CF,SF,ZF}
// committed on the edge leaving WB.
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : alu_sequencer_if.slave (handshake, ALU bus, done/wb_data/flags,
//           debug read)
// Instruction: opc[7:6] (00 NOR, 01 ROR, 10 LOADI, 11 NOP), rd[5:4],
// rs1[3:2], rs2[1:0].
module alu_sequencer #(
  parameter int WIDTH = 7,
  parameter int NREGS = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  alu_sequencer_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

  localparam logic [1:0] OP_NOR   = 2'b00;
  localparam logic [1:0] OP_ROR   = 2'b01;
  localparam logic [1:0] OP_LOADI = 2'b10;
  localparam logic [1:0] OP_NOP   = 2'b11;

  state_t                       state;
  logic [7:0]                   instr_q;
  logic [WIDTH-1:0]             imm_q;
  logic [WIDTH-1:0]             res_q;
  logic [2:0]                   fl_q;
  logic [NREGS-1:0][WIDTH-1:0]  rf;

  logic [1:0] opc, rd, rs1, rs2;
  assign opc = instr_q[7:6];
  assign rd  = instr_q[5:4];
  assign rs1 = instr_q[3:2];
  assign rs2 = instr_q[1:0];

  assign bus.instr_ready = (state == IDLE);
  assign bus.done        = (state == WB);
  // Held at zero outside WB so the bus is quiet between completions.
  assign bus.wb_data     = (state == WB) ? res_q : '0;
  assign bus.dbg_data    = rf[bus.dbg_addr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      instr_q    <= '0;
      imm_q      <= '0;
      res_q      <= '0;
      fl_q       <= '0;
      rf         <= '0;
      bus.alu_a  <= '0;
      bus.alu_b  <= '0;
      bus.alu_op <= 1'b0;
      bus.flags  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.instr_valid) begin
            instr_q <= bus.instr;
            imm_q   <= bus.imm;
            state   <= READ;
          end
        end
        READ: begin
          // Reads happen before any write of this instruction, so aliasing
          // rd with a source always sees the old value.
          bus.alu_a  <= rf[rs1];
          bus.alu_b  <= rf[rs2];
          bus.alu_op <= opc[0];
          state      <= EXEC;
        end
        EXEC: begin
          case (opc)
            OP_NOR, OP_ROR: begin
              res_q <= bus.alu_result;
              fl_q  <= {bus.alu_cf, bus.alu_sf, bus.alu_zf};
            end
            OP_LOADI: begin
              res_q <= imm_q;
              fl_q  <= {1'b0, imm_q[WIDTH-1], imm_q == '0};
            end
            default: res_q <= '0;  // NOP: fl_q untouched, never committed
          endcase
          state <= WB;
        end
        WB: begin
          if (opc != OP_NOP) begin
            rf[rd]    <= res_q;
            bus.flags <= fl_q;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_sequencer.sv
module tb_alu_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;

  alu_sequencer_if #(.WIDTH(7), .NREGS(4)) bus ();

  alu_sequencer #(.WIDTH(7), .NREGS(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // 7-bit rotate right by (b mod 7)
  function automatic logic [6:0] ror7(input logic [6:0] a, input logic [6:0] b);
    logic [13:0] d;
    int amt;
    amt = int'(b) % 7;
    d   = {a, a} >> amt;
    return d[6:0];
  endfunction

  // Behavioural ALU: CF=0, SF=result[6], ZF=(result==0)
  logic [6:0] alu_res;
  assign alu_res        = bus.alu_op ? ror7(bus.alu_a, bus.alu_b) : ~(bus.alu_a | bus.alu_b);
  assign bus.alu_result = alu_res;
  assign bus.alu_cf     = 1'b0;
  assign bus.alu_sf     = alu_res[6];
  assign bus.alu_zf     = (alu_res == 7'd0);

  // Scoreboard and architectural model (state after every issued instruction)
  typedef struct packed {
    logic [6:0] res;
    int         done_cyc;
  } exp_t;
  exp_t       exp_q[$];
  logic [6:0] m_rf[4];
  logic [2:0] m_flags;

  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_done: done=1 at cycle %0d with no instruction pending", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (bus.wb_data !== e.res) begin
          n_bad++;
          $display("FAIL wb_data: got %h expected %h", bus.wb_data, e.res);
        end
        n_vec++;
        if (cyc != e.done_cyc) begin
          n_bad++;
          $display("FAIL done_latency: done at cycle %0d expected %0d", cyc, e.done_cyc);
        end
      end
    end
  end

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_rf[i] = 7'd0;
    m_flags = 3'b000;
    exp_q.delete();
  endtask

  task automatic issue(input logic [1:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                       input logic [1:0] rs2, input logic [6:0] im, input bit hold,
                       output int acc_cyc);
    int   n;
    exp_t e;
    logic [6:0] r;
    logic [2:0] f;
    n = 0;
    @(negedge clk);
    while (bus.instr_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    acc_cyc = cyc;
    if (n >= 20) begin
      n_vec++;
      n_bad++;
      $display("FAIL ready_timeout: instr_ready=%b expected 1 within 20 cycles", bus.instr_ready);
      return;
    end
    case (op)
      2'd0: begin r = ~(m_rf[rs1] | m_rf[rs2]); f = {1'b0, r[6], r == 7'd0}; end
      2'd1: begin r = ror7(m_rf[rs1], m_rf[rs2]); f = {1'b0, r[6], r == 7'd0}; end
      2'd2: begin r = im; f = {1'b0, im[6], im == 7'd0}; end
      default: begin r = 7'd0; f = m_flags; end
    endcase
    if (op != 2'd3) begin
      m_rf[rd] = r;
      m_flags  = f;
    end
    e.res = r;
    e.done_cyc = cyc + 3;
    exp_q.push_back(e);
    bus.instr_valid = 1'b1;
    bus.instr       = {op, rd, rs1, rs2};
    bus.imm         = im;
    @(negedge clk);
    if (!hold) begin
      bus.instr_valid = 1'b0;
      bus.instr       = $urandom_range(0, 255);
      bus.imm         = $urandom_range(0, 127);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL done_timeout: %0d completions outstanding after 20 cycles", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    bus.instr_valid = 1'b0;
    bus.instr = 8'd0;
    bus.imm = 7'd0;
    bus.dbg_addr = 2'd0;
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++; if (bus.instr_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b expected 1", bus.instr_ready); end
    n_vec++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    n_vec++; if (bus.wb_data !== 7'd0) begin n_bad++; $display("FAIL reset_wb_data: got %h expected 00", bus.wb_data); end
    n_vec++; if (bus.flags !== 3'b000) begin n_bad++; $display("FAIL reset_flags: got %b expected 000", bus.flags); end
    n_vec++; if ({bus.alu_a, bus.alu_b, bus.alu_op} !== 15'd0) begin n_bad++; $display("FAIL reset_alu: got a=%h b=%h op=%b expected 0", bus.alu_a, bus.alu_b, bus.alu_op); end
    for (int i = 0; i < 4; i++) begin
      bus.dbg_addr = 2'(i);
      #1;
      n_vec++; if (bus.dbg_data !== 7'd0) begin n_bad++; $display("FAIL reset_rf%0d: got %h expected 00", i, bus.dbg_data); end
    end
  endtask

  task automatic test_loadi();
    int a;
    issue(2'd2, 2'd1, 2'd0, 2'd0, 7'h55, 1'b0, a);
    wait_idle();
    bus.dbg_addr = 2'd1;
    #1;
    n_vec++; if (bus.flags !== 3'b010) begin n_bad++; $display("FAIL loadi_flags: got %b expected 010", bus.flags); end
    n_vec++; if (bus.dbg_data !== 7'h55) begin n_bad++; $display("FAIL loadi_r1: got %h expected 55", bus.dbg_data); end
    n_vec++; if (bus.instr_ready !== 1'b1) begin n_bad++; $display("FAIL loadi_ready: got %b expected 1", bus.instr_ready); end
  endtask

  task automatic test_nor();
    int a;
    issue(2'd0, 2'd2, 2'd1, 2'd0, 7'h00, 1'b0, a);
    @(negedge clk);  // EXEC cycle
    n_vec++; if ({bus.alu_a, bus.alu_b, bus.alu_op} !== {7'h55, 7'h00, 1'b0}) begin
      n_bad++; $display("FAIL nor_operands: got a=%h b=%h op=%b expected a=55 b=00 op=0", bus.alu_a, bus.alu_b, bus.alu_op);
    end
    wait_idle();
    bus.dbg_addr = 2'd2;
    #1;
    n_vec++; if (bus.flags !== 3'b000) begin n_bad++; $display("FAIL nor_flags: got %b expected 000", bus.flags); end
    n_vec++; if (bus.dbg_data !== 7'h2A) begin n_bad++; $display("FAIL nor_r2: got %h expected 2a", bus.dbg_data); end
  endtask

  task automatic test_ror();
    int a;
    issue(2'd2, 2'd0, 2'd0, 2'd0, 7'h03, 1'b0, a);
    wait_idle();
    issue(2'd1, 2'd3, 2'd1, 2'd0, 7'h00, 1'b0, a);
    wait_idle();
    bus.dbg_addr = 2'd3;
    #1;
    n_vec++; if (bus.flags !== 3'b010) begin n_bad++; $display("FAIL ror_flags: got %b expected 010", bus.flags); end
    n_vec++; if (bus.dbg_data !== 7'h5A) begin n_bad++; $display("FAIL ror_r3: got %h expected 5a", bus.dbg_data); end
  endtask

  task automatic test_alias();
    int a;
    issue(2'd2, 2'd2, 2'd0, 2'd0, 7'h7F, 1'b0, a);
    wait_idle();
    issue(2'd0, 2'd2, 2'd2, 2'd2, 7'h00, 1'b0, a);
    wait_idle();
    bus.dbg_addr = 2'd2;
    #1;
    n_vec++; if (bus.flags !== 3'b001) begin n_bad++; $display("FAIL alias_flags: got %b expected 001", bus.flags); end
    n_vec++; if (bus.dbg_data !== 7'h00) begin n_bad++; $display("FAIL alias_r2: got %h expected 00", bus.dbg_data); end
  endtask

  task automatic test_back_to_back();
    int a0, a1, a2;
    issue(2'd2, 2'd3, 2'd0, 2'd0, 7'h40, 1'b1, a0);       // LOADI r3=0x40, flags 010
    issue(2'd3, 2'd1, 2'd3, 2'd3, 7'h00, 1'b1, a1);       // NOP aimed at r1
    n_vec++; if (a1 - a0 != 4) begin n_bad++; $display("FAIL b2b_spacing1: got %0d cycles expected 4", a1 - a0); end
    issue(2'd0, 2'd0, 2'd3, 2'd1, 7'h00, 1'b0, a2);       // NOR r0=r3,r1 -> 0x2a
    n_vec++; if (a2 - a1 != 4) begin n_bad++; $display("FAIL b2b_spacing2: got %0d cycles expected 4", a2 - a1); end
    // NOP has committed, NOR has not: flags still from the LOADI
    bus.dbg_addr = 2'd1;
    #1;
    n_vec++; if (bus.flags !== 3'b010) begin n_bad++; $display("FAIL nop_flags: got %b expected 010", bus.flags); end
    n_vec++; if (bus.dbg_data !== 7'h55) begin n_bad++; $display("FAIL nop_r1: got %h expected 55", bus.dbg_data); end
    wait_idle();
    bus.dbg_addr = 2'd0;
    #1;
    n_vec++; if (bus.dbg_data !== 7'h2A) begin n_bad++; $display("FAIL b2b_r0: got %h expected 2a", bus.dbg_data); end
    n_vec++; if (bus.flags !== 3'b000) begin n_bad++; $display("FAIL b2b_flags: got %b expected 000", bus.flags); end
  endtask

  task automatic test_random();
    int a;
    logic [1:0] op, rd;
    for (int k = 0; k < 10; k++) begin
      op = 2'($urandom_range(0, 3));
      rd = 2'($urandom_range(0, 3));
      issue(op, rd, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 7'($urandom_range(0, 127)), 1'b0, a);
      wait_idle();
      bus.dbg_addr = rd;
      #1;
      n_vec++; if (bus.flags !== m_flags) begin n_bad++; $display("FAIL rand_flags[%0d]: got %b expected %b", k, bus.flags, m_flags); end
      n_vec++; if (bus.dbg_data !== m_rf[rd]) begin n_bad++; $display("FAIL rand_rf[%0d]: r%0d got %h expected %h", k, rd, bus.dbg_data, m_rf[rd]); end
    end
    for (int i = 0; i < 4; i++) begin
      bus.dbg_addr = 2'(i);
      #1;
      n_vec++; if (bus.dbg_data !== m_rf[i]) begin n_bad++; $display("FAIL rand_final_r%0d: got %h expected %h", i, bus.dbg_data, m_rf[i]); end
    end
  endtask

  task automatic test_reset_mid();
    int a;
    issue(2'd2, 2'd1, 2'd0, 2'd0, 7'h11, 1'b0, a);
    @(negedge clk);  // EXEC cycle
    rst_n = 1'b0;
    model_reset();   // aborted instruction must not complete
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    bus.dbg_addr = 2'd1;
    #1;
    n_vec++; if (bus.instr_ready !== 1'b1) begin n_bad++; $display("FAIL rstmid_ready: got %b expected 1", bus.instr_ready); end
    n_vec++; if (bus.flags !== 3'b000) begin n_bad++; $display("FAIL rstmid_flags: got %b expected 000", bus.flags); end
    n_vec++; if (bus.dbg_data !== 7'h00) begin n_bad++; $display("FAIL rstmid_r1: got %h expected 00", bus.dbg_data); end
  endtask

  initial begin
    test_reset();
    test_loadi();
    test_nor();
    test_ror();
    test_alias();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
